// File: rtl/regfile_write_buffer_pkg.sv
// Shared types and helpers for the register-file write buffer: the queued
// entry layout, the bypass match result and the youngest-match search.
package regfile_wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DEPTH      = 4;

    // Register 0 is hard-wired; writes to it never enter the queue.
    localparam logic [WB_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic                     hit;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_match_t;

    // Entries arrive ordered oldest (index 0) to youngest, so a later match
    // simply overrides an earlier one. Data stays zero when nothing matches.
    function automatic wb_match_t youngest_match(
        input wb_entry_t [WB_DEPTH-1:0] entries,
        input logic      [WB_DEPTH-1:0] valid,
        input logic [WB_ADDR_WIDTH-1:0] addr
    );
        wb_match_t m;
        m = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == addr)) begin
                m.hit  = 1'b1;
                m.data = entries[i].data;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_write_buffer_if.sv
// Bus between the pipeline/auxiliary unit and the write buffer: write
// requests, auxiliary handshake, bypass queries and the register-file port.
interface regfile_write_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  pipe_wr_en;
    logic [ADDR_WIDTH-1:0] pipe_wr_addr;
    logic [DATA_WIDTH-1:0] pipe_wr_data;
    logic                  aux_valid;
    logic                  aux_ready;
    logic [ADDR_WIDTH-1:0] aux_addr;
    logic [DATA_WIDTH-1:0] aux_data;
    logic                  stall;
    logic                  overflow;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] lookup_addr1;
    logic [ADDR_WIDTH-1:0] lookup_addr2;
    logic                  hit1;
    logic                  hit2;
    logic [DATA_WIDTH-1:0] fwd_data1;
    logic [DATA_WIDTH-1:0] fwd_data2;
    logic                  rf_write_en;
    logic [ADDR_WIDTH-1:0] rf_address_write;
    logic [DATA_WIDTH-1:0] rf_write_data;

    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output aux_valid, aux_addr, aux_data,
        output lookup_addr1, lookup_addr2,
        input  aux_ready, stall, overflow, count,
        input  hit1, hit2, fwd_data1, fwd_data2,
        input  rf_write_en, rf_address_write, rf_write_data
    );

    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  aux_valid, aux_addr, aux_data,
        input  lookup_addr1, lookup_addr2,
        output aux_ready, stall, overflow, count,
        output hit1, hit2, fwd_data1, fwd_data2,
        output rf_write_en, rf_address_write, rf_write_data
    );

endinterface

// File: rtl/regfile_write_buffer_queue.sv
// Dual-push, single-pop circular buffer. push0 is the older of two
// same-cycle pushes. Pointers carry one extra wrap bit so full and empty
// differ only in that MSB and occupancy is a plain subtraction.
module wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push0_en,
    input  wb_entry_t                     push0_entry,
    input  logic                          push1_en,
    input  wb_entry_t                     push1_entry,
    input  logic                          pop_en,
    output wb_entry_t                     head_entry,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output wb_entry_t [DEPTH-1:0]         age_entries,
    output logic [DEPTH-1:0]              age_valid
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  head_ptr;
    logic [PW-1:0]  tail_ptr;
    logic [IW-1:0]  tail_idx;
    logic [IW-1:0]  tail_idx_next;

    assign tail_idx      = tail_ptr[IW-1:0];
    assign tail_idx_next = tail_idx + IW'(1);
    assign count         = tail_ptr - head_ptr;
    assign empty         = (head_ptr == tail_ptr);
    assign head_entry    = mem[head_ptr[IW-1:0]];

    // Storage: a lone push lands at the tail; a pair lands push0 then push1.
    always_ff @(posedge clk) begin
        if (push0_en) begin
            mem[tail_idx] <= push0_entry;
        end
        if (push1_en) begin
            if (push0_en) begin
                mem[tail_idx_next] <= push1_entry;
            end else begin
                mem[tail_idx] <= push1_entry;
            end
        end
    end

    // Pointer advance; tail moves by the number of pushes, head by the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            tail_ptr <= tail_ptr + PW'(push0_en) + PW'(push1_en);
            if (pop_en) begin
                head_ptr <= head_ptr + PW'(1);
            end
        end
    end

    // Age-ordered view from head (oldest) onward for the bypass search.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entries[i] = mem[head_ptr[IW-1:0] + IW'(i)];
            age_valid[i]   = (PW'(i) < count);
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Write-side front end of the register file: merges pipeline and auxiliary
// writebacks into an in-order queue, drains one entry per cycle onto the
// file's write port and offers two bypass lookups over pending values.
module regfile_write_buffer
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = WB_DEPTH
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_write_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]          count;
    logic                   queue_empty;
    logic                   stall;
    logic                   aux_ready;
    logic                   push_aux;
    logic                   push_pipe;
    logic                   pop;
    wb_entry_t              aux_entry;
    wb_entry_t              pipe_entry;
    wb_entry_t              head_entry;
    wb_entry_t [DEPTH-1:0]  age_entries;
    logic [DEPTH-1:0]       age_valid;
    logic                   overflow_q;
    logic                   rf_write_en_q;
    logic [ADDR_WIDTH-1:0]  rf_address_write_q;
    logic [DATA_WIDTH-1:0]  rf_write_data_q;
    wb_match_t              match1;
    wb_match_t              match2;
    logic                   hit1;
    logic                   hit2;
    logic [DATA_WIDTH-1:0]  fwd_data1;
    logic [DATA_WIDTH-1:0]  fwd_data2;

    // Stall keeps two free slots so an aux and a pipe write can always land
    // together; with fewer free slots aux may still use the last one when the
    // pipeline is quiet.
    assign stall     = (CW'(DEPTH) - count) < CW'(2);
    assign aux_ready = !stall || ((count < CW'(DEPTH)) && !bus.pipe_wr_en);

    // Writes to register 0 complete their handshake but never occupy a slot.
    assign push_aux   = bus.aux_valid && aux_ready && (bus.aux_addr != REG_ZERO);
    assign push_pipe  = bus.pipe_wr_en && !stall && (bus.pipe_wr_addr != REG_ZERO);
    assign pop        = !queue_empty;
    assign aux_entry  = '{addr: bus.aux_addr, data: bus.aux_data};
    assign pipe_entry = '{addr: bus.pipe_wr_addr, data: bus.pipe_wr_data};

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0_en    (push_aux),
        .push0_entry (aux_entry),
        .push1_en    (push_pipe),
        .push1_entry (pipe_entry),
        .pop_en      (pop),
        .head_entry  (head_entry),
        .empty       (queue_empty),
        .count       (count),
        .age_entries (age_entries),
        .age_valid   (age_valid)
    );

    // Register-file port: the head moves here each cycle the queue has data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en_q      <= 1'b0;
            rf_address_write_q <= '0;
            rf_write_data_q    <= '0;
        end else if (pop) begin
            rf_write_en_q      <= 1'b1;
            rf_address_write_q <= head_entry.addr;
            rf_write_data_q    <= head_entry.data;
        end else begin
            rf_write_en_q      <= 1'b0;
        end
    end

    // Sticky flag for a pipeline write that arrived while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (bus.pipe_wr_en && stall) begin
            overflow_q <= 1'b1;
        end
    end

    // Bypass: queue entries outrank the output register, register 0 never hits.
    always_comb begin
        match1    = youngest_match(age_entries, age_valid, bus.lookup_addr1);
        match2    = youngest_match(age_entries, age_valid, bus.lookup_addr2);
        hit1      = match1.hit;
        fwd_data1 = match1.data;
        hit2      = match2.hit;
        fwd_data2 = match2.data;
        if (!match1.hit && rf_write_en_q && (rf_address_write_q == bus.lookup_addr1)) begin
            hit1      = 1'b1;
            fwd_data1 = rf_write_data_q;
        end
        if (!match2.hit && rf_write_en_q && (rf_address_write_q == bus.lookup_addr2)) begin
            hit2      = 1'b1;
            fwd_data2 = rf_write_data_q;
        end
        if (bus.lookup_addr1 == REG_ZERO) begin
            hit1      = 1'b0;
            fwd_data1 = '0;
        end
        if (bus.lookup_addr2 == REG_ZERO) begin
            hit2      = 1'b0;
            fwd_data2 = '0;
        end
    end

    assign bus.stall            = stall;
    assign bus.aux_ready        = aux_ready;
    assign bus.count            = count;
    assign bus.overflow         = overflow_q;
    assign bus.hit1             = hit1;
    assign bus.hit2             = hit2;
    assign bus.fwd_data1        = fwd_data1;
    assign bus.fwd_data2        = fwd_data2;
    assign bus.rf_write_en      = rf_write_en_q;
    assign bus.rf_address_write = rf_address_write_q;
    assign bus.rf_write_data    = rf_write_data_q;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: a reference occupancy/overflow model
// predicts acceptance, accepted writes go into an expected queue, and a
// negedge monitor pops and compares every register-file write.
module tb_regfile_write_buffer;
    import regfile_wb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    int        tests_run    = 0;
    int        tests_failed = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_entry;
    int        model_count;
    logic      model_overflow;
    logic [DW-1:0] obs_file [32];

    regfile_write_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    regfile_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of requests, checks status against the model, and
    // records the writes the model says will be accepted.
    task automatic applyStimulus(input logic pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                                 input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        logic exp_stall;
        logic exp_ready;
        int   pushes;
        int   pops;
        @(negedge clk);
        bus.pipe_wr_en   = pe;
        bus.pipe_wr_addr = pa;
        bus.pipe_wr_data = pd;
        bus.aux_valid    = av;
        bus.aux_addr     = aa;
        bus.aux_data     = ad;
        #1;
        exp_stall = (DEPTH - model_count) < 2;
        exp_ready = !exp_stall || ((model_count < DEPTH) && !pe);
        checkOutput("count", 64'(bus.count), 64'(model_count));
        checkOutput("stall", 64'(bus.stall), 64'(exp_stall));
        checkOutput("aux_ready", 64'(bus.aux_ready), 64'(exp_ready));
        checkOutput("overflow", 64'(bus.overflow), 64'(model_overflow));
        pushes = 0;
        if (av && exp_ready && (aa != 0)) begin
            exp_q.push_back('{addr: aa, data: ad});
            pushes++;
        end
        if (pe && !exp_stall && (pa != 0)) begin
            exp_q.push_back('{addr: pa, data: pd});
            pushes++;
        end
        if (pe && exp_stall) model_overflow = 1'b1;
        pops = (model_count > 0) ? 1 : 0;
        @(posedge clk);
        model_count = model_count + pushes - pops;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drainQueue();
        for (int i = 0; (i < 16) && ((exp_q.size() > 0) || (model_count > 0)); i++) idleCycle();
        idleCycle();
        checkOutput("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic setLookup(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.lookup_addr1 = a1;
        bus.lookup_addr2 = a2;
        #1;
    endtask

    // Write monitor: every file write must be the oldest expected entry.
    always @(negedge clk) begin
        if ((rst_n === 1'b1) && (bus.rf_write_en === 1'b1)) begin
            obs_file[bus.rf_address_write] = bus.rf_write_data;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 64'(bus.rf_write_en), 64'd0);
            end else begin
                mon_entry = exp_q.pop_front();
                checkOutput("wr_addr", 64'(bus.rf_address_write), 64'(mon_entry.addr));
                checkOutput("wr_data", 64'(bus.rf_write_data), 64'(mon_entry.data));
            end
        end
    end

    // Hard bound on run time.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) obs_file[i] = '0;
        bus.pipe_wr_en = 1'b0; bus.pipe_wr_addr = '0; bus.pipe_wr_data = '0;
        bus.aux_valid  = 1'b0; bus.aux_addr     = '0; bus.aux_data     = '0;
        bus.lookup_addr1 = '0; bus.lookup_addr2 = '0;
        model_count = 0;
        model_overflow = 1'b0;
        rst_n = 1'b0;
        #12;
        checkOutput("rst_count", 64'(bus.count), 64'd0);
        checkOutput("rst_wen", 64'(bus.rf_write_en), 64'd0);
        checkOutput("rst_addr", 64'(bus.rf_address_write), 64'd0);
        checkOutput("rst_data", 64'(bus.rf_write_data), 64'd0);
        checkOutput("rst_overflow", 64'(bus.overflow), 64'd0);
        checkOutput("rst_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pipe write: queued after edge N, on the port after N+1.
        applyStimulus(1'b1, 5'd1, 32'h12345678, 1'b0, '0, '0);
        setLookup(5'd1, 5'd0);
        checkOutput("t1_wen_early", 64'(bus.rf_write_en), 64'd0);
        checkOutput("t1_hit_queue", 64'(bus.hit1), 64'd1);
        checkOutput("t1_fwd_queue", 64'(bus.fwd_data1), 64'h12345678);
        checkOutput("t1_hit2_zero", 64'(bus.hit2), 64'd0);
        checkOutput("t1_fwd2_zero", 64'(bus.fwd_data2), 64'd0);
        idleCycle();
        checkOutput("t1_wen", 64'(bus.rf_write_en), 64'd1);
        checkOutput("t1_addr", 64'(bus.rf_address_write), 64'd1);
        checkOutput("t1_data", 64'(bus.rf_write_data), 64'h12345678);
        checkOutput("t1_hit_outreg", 64'(bus.hit1), 64'd1);
        checkOutput("t1_fwd_outreg", 64'(bus.fwd_data1), 64'h12345678);
        idleCycle();
        checkOutput("t1_wen_off", 64'(bus.rf_write_en), 64'd0);
        checkOutput("t1_hit_gone", 64'(bus.hit1), 64'd0);

        // Writes to register 0 are discarded.
        applyStimulus(1'b1, 5'd0, 32'hFFAAFFAA, 1'b1, 5'd0, 32'h00000055);
        setLookup(5'd0, 5'd0);
        checkOutput("t2_count", 64'(bus.count), 64'd0);
        checkOutput("t2_hit", 64'(bus.hit1), 64'd0);
        checkOutput("t2_fwd", 64'(bus.fwd_data1), 64'd0);
        idleCycle();
        checkOutput("t2_wen", 64'(bus.rf_write_en), 64'd0);

        // Same-cycle aux and pipe to one register: pipe is younger.
        applyStimulus(1'b1, 5'd3, 32'h0000000B, 1'b1, 5'd3, 32'h0000000A);
        setLookup(5'd3, 5'd1);
        checkOutput("t3_count", 64'(bus.count), 64'd2);
        checkOutput("t3_hit", 64'(bus.hit1), 64'd1);
        checkOutput("t3_fwd", 64'(bus.fwd_data1), 64'hB);
        checkOutput("t3_stale_hit", 64'(bus.hit2), 64'd0);
        idleCycle();
        checkOutput("t3_first_data", 64'(bus.rf_write_data), 64'hA);
        checkOutput("t3_fwd_young", 64'(bus.fwd_data1), 64'hB);
        drainQueue();
        checkOutput("t3_file", 64'(obs_file[3]), 64'hB);

        // Paired writes fill the queue to the stall point and wrap pointers.
        applyStimulus(1'b1, 5'd5, 32'h00000505, 1'b1, 5'd4, 32'h00000404);
        applyStimulus(1'b1, 5'd7, 32'h00000707, 1'b1, 5'd6, 32'h00000606);
        checkOutput("t4_stall", 64'(bus.stall), 64'd1);
        setLookup(5'd6, 5'd7);
        checkOutput("t4_fwd6", 64'(bus.fwd_data1), 64'h606);
        checkOutput("t4_fwd7", 64'(bus.fwd_data2), 64'h707);
        drainQueue();
        checkOutput("t4_overflow", 64'(bus.overflow), 64'd0);

        // Pipe write under stall is dropped and sets overflow; aux alone may
        // still take the last slot.
        applyStimulus(1'b1, 5'd11, 32'h00001111, 1'b1, 5'd10, 32'h00001010);
        applyStimulus(1'b1, 5'd13, 32'h00001313, 1'b1, 5'd12, 32'h00001212);
        applyStimulus(1'b1, 5'd14, 32'h0000DEAD, 1'b1, 5'd15, 32'h0000BEEF);
        checkOutput("t5_overflow", 64'(bus.overflow), 64'd1);
        applyStimulus(1'b1, 5'd17, 32'h00001717, 1'b1, 5'd16, 32'h00001616);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd18, 32'h00001818);
        setLookup(5'd14, 5'd18);
        checkOutput("t5_dropped_hit", 64'(bus.hit1), 64'd0);
        checkOutput("t5_aux_fwd", 64'(bus.fwd_data2), 64'h1818);
        drainQueue();
        checkOutput("t5_overflow_sticky", 64'(bus.overflow), 64'd1);

        // Asynchronous reset with entries pending discards them.
        applyStimulus(1'b1, 5'd21, 32'h00002121, 1'b1, 5'd20, 32'h00002020);
        applyStimulus(1'b1, 5'd23, 32'h00002323, 1'b1, 5'd22, 32'h00002222);
        #2;
        rst_n = 1'b0;
        bus.pipe_wr_en = 1'b0;
        bus.aux_valid  = 1'b0;
        #1;
        exp_q.delete();
        model_count = 0;
        model_overflow = 1'b0;
        checkOutput("t6_wen", 64'(bus.rf_write_en), 64'd0);
        checkOutput("t6_count", 64'(bus.count), 64'd0);
        checkOutput("t6_overflow", 64'(bus.overflow), 64'd0);
        setLookup(5'd22, 5'd23);
        checkOutput("t6_hit", 64'(bus.hit1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idleCycle();
        checkOutput("t6_no_stale", 64'(obs_file[22]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
